apb4_mem_slave: RTL and testbench
=================================

// Module: apb4_mem_slave
// PURPOSE
//  Parametrised APB4 completer backed by a word-organised memory. Next-generation memory slave:
//  configurable data/address width and depth, byte strobes (PSTRB), deterministic
//  programmable wait states, decoded PSLVERR causes. Sits behind the APB requester/bridge as
//  the per-PSEL target used by the UVM environment and SoC-level tests.
// PARAMETERS
//  ADDR_WIDTH  32  width of _PADDR (byte address)
//  DATA_WIDTH  32  width of _PWDATA/_PRDATA; legal values 8,16,32,64
//  DEPTH       5   log2 of number of words (2**DEPTH words)
// PORTS
//  _PCLK     in   1              bus clock; all logic on rising edge
//  _PRESET   in   1              reset, synchronous, active-high
//  _PSEL     in   1              select for this completer
//  _PENABLE  in   1              access-phase indicator
//  _PWRITE   in   1              1 = write, 0 = read
//  _PADDR    in   ADDR_WIDTH     byte address
//  _PWDATA   in   DATA_WIDTH     write data
//  _PSTRB    in   DATA_WIDTH/8   write byte-lane enables
//  _WAIT     in   4              wait states inserted per transfer, sampled in setup phase
//  _PRDATA   out  DATA_WIDTH     read data, registered
//  _PREADY   out  1              transfer-complete, registered
//  _PSLVERR  out  1              error, registered, valid only while _PREADY=1
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  - Reset: state=IDLE; _PREADY=0, _PSLVERR=0, _PRDATA=0; written-bitmap cleared.
//  - Memory array is not reset.
//  - Reset mid-transfer aborts the transfer with no write commit.
//  FSM (3 states):
//  - IDLE: on _PSEL & !_PENABLE (setup phase) latch addr/dir/strb/data.
//    -> READY if _WAIT==0; otherwise -> WAIT with cnt=_WAIT.
//  - WAIT: cnt decrements each cycle; cnt==1 -> READY.
//    !_PSEL or !_PENABLE while in WAIT -> IDLE (abort, no commit).
//  - READY: _PREADY=1 for exactly one cycle, then -> IDLE. Back-to-back setup in the next
//    cycle is taken by IDLE.
//  - Latency: _PREADY rises in access cycle 1+_WAIT (1 = first cycle with _PENABLE=1).
//  Outputs:
//  - _PRDATA and _PSLVERR are registered on the edge that enters READY.
//  - Both are 0 whenever _PREADY=0.
//  Word index = _PADDR[DEPTH+B-1:B], where B = log2(DATA_WIDTH/8).
//  Error decode, priority high to low:
//  - (1) _PADDR >= 2**(DEPTH+B): out of range.
//  - (2) _PADDR[B-1:0] != 0: misaligned.
//  - (3) read of a word whose written bit is 0.
//  - Any error: _PSLVERR=1, _PRDATA=0, no memory or bitmap update.
//  Write commit: on the edge that ends READY, if no error.
//  - Per lane i, mem[idx][8i+:8] <= wdata when strb[i]=1.
//  - Written bit set only if strb != 0. strb == 0 is a legal no-op write with _PSLVERR=0.
//  - Unwritten lanes of a written word are undefined on read.
//  Read: _PSTRB ignored. Read-after-write to the same word returns the new data; it is always
//  >= 2 cycles later, so no bypass is needed.
//  _PADDR/_PWRITE/_PWDATA changes after the setup phase are ignored (latched copy used).
// STRUCTURE
//  Package apb_mem_pkg:
//  - state_t enum {IDLE, WAIT, READY}.
//  - err_t {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_UNWRITTEN}.
//  - Function lane_bits(DATA_WIDTH).
//  Sub-module apb_bytelane_ram #(DATA_WIDTH, DEPTH):
//  - Byte-enabled synchronous-write, async-read array plus written-bitmap with synchronous clear.
//  - Top level holds the FSM, wait counter, decode and output registers.
// TESTING  (DATA_WIDTH=32, DEPTH=5 unless noted)
//  1 Write 0xA5A5_1234 @0x10, strb=4'hF, _WAIT=0; read 0x10
//    -> _PREADY in 1st access cycle; _PRDATA=0xA5A5_1234; _PSLVERR=0.
//  2 _WAIT=3, write @0x04 -> _PREADY=0 for 3 access cycles, high on 4th, for exactly one cycle.
//  3 Write 0xFFFF_FFFF strb=F @0x20, then 0x0000_0000 strb=4'b0101; read
//    -> 0xFF00_FF00.
//  4 Read @0x7C never written -> _PSLVERR=1, _PRDATA=0.
//    Write @0x80 -> _PSLVERR=1, no write.
//    Write @0x02 -> _PSLVERR=1 (misaligned).
//  5 _WAIT=5, write @0x08; drop _PSEL after 2 wait cycles; then read @0x08
//    -> _PSLVERR=1 (unwritten).
//  6 Assert _PRESET in WAIT of a write @0x0C
//    -> outputs 0 the next cycle; a subsequent read of any address errors (bitmap cleared).

Source files
------------

// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_pkg
// Purpose  : Shared types and helpers for the APB4 memory completer.
//            state_t - completer FSM states
//            err_t   - decoded PSLVERR cause
//            lane_bits() - number of byte-offset address bits for a data width
// Revision : 1.0 - initial release
// ============================================================================
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_RANGE     = 2'd1,
    ERR_ALIGN     = 2'd2,
    ERR_UNWRITTEN = 2'd3
  } err_t;

  // Byte-offset bits inside one data word (0 for 8-bit, 3 for 64-bit).
  function automatic int lane_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_bytelane_ram.sv
`default_nettype none
// ============================================================================
// Module   : apb_bytelane_ram
// Purpose  : Word-organised array with per-byte write enables, synchronous
//            write and asynchronous read, plus a per-word "written" bitmap
//            that is cleared synchronously by reset. The data array itself
//            is never reset.
// Ports    : i_clk      clock (rising edge)
//            i_rst      synchronous active-high clear of the written bitmap
//            i_we       write commit strobe
//            i_waddr    word index for the write
//            i_wdata    write data
//            i_wstrb    byte-lane enables for the write
//            i_raddr    word index for the read
//            o_rdata    read data (combinational)
//            o_written  written bit of word i_raddr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module apb_bytelane_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [DEPTH-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DEPTH-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_written
);

  localparam int c_WORDS = 1 << DEPTH;
  localparam int c_LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [c_WORDS];
  logic [c_WORDS-1:0]    r_written;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (i_wstrb[i]) begin
          r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // A zero-strobe write is a legal no-op and must not mark the word valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_written <= '0;
    end else if (i_we && (|i_wstrb)) begin
      r_written[i_waddr] <= 1'b1;
    end
  end

  assign o_rdata   = r_mem[i_raddr];
  assign o_written = r_written[i_raddr];

endmodule
`default_nettype wire

// File: rtl/apb4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb4_mem_slave
// Purpose  : APB4 completer backed by a byte-strobed word memory, with
//            programmable wait states and decoded PSLVERR causes
//            (out of range > misaligned > read of unwritten word).
// Ports    : i_PCLK     bus clock
//            i_PRESET   synchronous active-high reset
//            i_PSEL     completer select
//            i_PENABLE  access-phase indicator
//            i_PWRITE   1 = write, 0 = read
//            i_PADDR    byte address
//            i_PWDATA   write data
//            i_PSTRB    write byte-lane enables
//            i_WAIT     wait states for this transfer (sampled in setup)
//            o_PRDATA   registered read data, 0 unless o_PREADY
//            o_PREADY   registered one-cycle transfer completion
//            o_PSLVERR  registered error, 0 unless o_PREADY
// Revision : 1.0 - initial release
// ============================================================================
module apb4_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 5
) (
  input  logic                    i_PCLK,
  input  logic                    i_PRESET,
  input  logic                    i_PSEL,
  input  logic                    i_PENABLE,
  input  logic                    i_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   i_PADDR,
  input  logic [DATA_WIDTH-1:0]   i_PWDATA,
  input  logic [DATA_WIDTH/8-1:0] i_PSTRB,
  input  logic [3:0]              i_WAIT,
  output logic [DATA_WIDTH-1:0]   o_PRDATA,
  output logic                    o_PREADY,
  output logic                    o_PSLVERR
);

  localparam int c_B     = lane_bits(DATA_WIDTH);
  localparam int c_SPAN  = DEPTH + c_B;
  localparam int c_NSTRB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'((64'd1 << c_B) - 64'd1);

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_NSTRB-1:0]      r_strb;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;

  logic                    w_setup;
  logic [ADDR_WIDTH-1:0]   w_dec_addr;
  logic                    w_dec_write;
  logic [DEPTH-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_written;
  logic                    w_we;
  err_t                    w_err;

  assign w_setup = i_PSEL & ~i_PENABLE;

  // With zero wait states the outputs are loaded on the setup edge itself,
  // before the latched copy exists, so decode from the live bus in IDLE.
  assign w_dec_addr  = (r_state == IDLE) ? i_PADDR  : r_addr;
  assign w_dec_write = (r_state == IDLE) ? i_PWRITE : r_write;
  assign w_idx       = w_dec_addr[c_SPAN-1:c_B];

  always_comb begin
    w_err = ERR_NONE;
    if ((w_dec_addr >> c_SPAN) != '0) begin
      w_err = ERR_RANGE;
    end else if ((w_dec_addr & c_ALIGN_MASK) != '0) begin
      w_err = ERR_ALIGN;
    end else if (!w_dec_write && !w_written) begin
      w_err = ERR_UNWRITTEN;
    end
  end

  // Commit on the edge that leaves READY; r_pslverr holds the decoded error.
  assign w_we = (r_state == READY) && r_write && !r_pslverr && !i_PRESET;

  apb_bytelane_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk     (i_PCLK),
    .i_rst     (i_PRESET),
    .i_we      (w_we),
    .i_waddr   (r_addr[c_SPAN-1:c_B]),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_strb),
    .i_raddr   (w_idx),
    .o_rdata   (w_rdata),
    .o_written (w_written)
  );

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      // Outputs are zero outside the single READY cycle.
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_write <= i_PWRITE;
            r_addr  <= i_PADDR;
            r_wdata <= i_PWDATA;
            r_strb  <= i_PSTRB;
            if (i_WAIT == 4'd0) begin
              r_state   <= READY;
              r_pready  <= 1'b1;
              r_pslverr <= (w_err != ERR_NONE);
              r_prdata  <= (w_err == ERR_NONE && !w_dec_write) ? w_rdata : '0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= i_WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_PSEL || !i_PENABLE) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state   <= READY;
            r_pready  <= 1'b1;
            r_pslverr <= (w_err != ERR_NONE);
            r_prdata  <= (w_err == ERR_NONE && !w_dec_write) ? w_rdata : '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        READY: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_PREADY  = r_pready;
  assign o_PSLVERR = r_pslverr;
  assign o_PRDATA  = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_apb4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_mem_slave
// Purpose  : Self-checking bench for apb4_mem_slave (32-bit data, 32 words).
//            Directed scenarios followed by random transfers checked against
//            a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb, pwait;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bytes, which bytes hold defined data, which words are valid.
  logic [7:0] m_byte  [0:31][0:3];
  bit         m_known [0:31][0:3];
  bit         m_wr    [0:31];

  apb4_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (5)
  ) dut (
    .i_PCLK    (clk),
    .i_PRESET  (rst),
    .i_PSEL    (psel),
    .i_PENABLE (penable),
    .i_PWRITE  (pwrite),
    .i_PADDR   (paddr),
    .i_PWDATA  (pwdata),
    .i_PSTRB   (pstrb),
    .i_WAIT    (pwait),
    .o_PRDATA  (prdata),
    .o_PREADY  (pready),
    .o_PSLVERR (pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 32; w++) begin
      m_wr[w] = 1'b0;
      for (int l = 0; l < 4; l++) m_known[w][l] = 1'b0;
    end
  endtask

  // One complete APB transfer; bus fields are scrambled during the access
  // phase because the completer must work from its setup-phase copy.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int wt,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; pwait = 4'(wt);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
    pstrb = 4'($urandom); pwait = 4'($urandom);
    lat = 1;
    while (!pready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!pready) chk("pready_timeout", {63'd0, pready}, 64'd1);
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("outputs_after_ready", {31'd0, pready, pslverr, prdata}, 64'd0);
  endtask

  // Transfer plus model prediction and checks; returns observed read data.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int wt, output logic [31:0] rdata);
    logic        err;
    int          lat;
    bit          exp_err;
    int          idx;
    logic [31:0] exp_data, mask;
    xfer(wr, addr, wdata, strb, wt, rdata, err, lat);
    idx      = int'(addr[6:2]);
    exp_err  = (addr >= 32'd128) || (addr % 4 != 0) || (!wr && !m_wr[idx]);
    exp_data = 32'd0;
    mask     = 32'hFFFF_FFFF;
    if (!exp_err && !wr) begin
      for (int l = 0; l < 4; l++) begin
        exp_data[8*l +: 8] = m_byte[idx][l];
        mask[8*l +: 8]     = m_known[idx][l] ? 8'hFF : 8'h00;
      end
    end
    chk("pslverr", {63'd0, err}, {63'd0, exp_err});
    chk("prdata", {32'd0, rdata & mask}, {32'd0, exp_data & mask});
    chk("latency", 64'(lat), 64'(wt + 1));
    if (wr && !exp_err) begin
      for (int l = 0; l < 4; l++) begin
        if (strb[l]) begin
          m_byte[idx][l]  = wdata[8*l +: 8];
          m_known[idx][l] = 1'b1;
        end
      end
      if (strb != 4'd0) m_wr[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          r;

    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pwait = 0;
    rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {31'd0, pready, pslverr, prdata}, 64'd0);
    rst = 1'b0;

    // 1: zero-wait write then read back
    txn(1, 32'h10, 32'hA5A5_1234, 4'hF, 0, rd);
    txn(0, 32'h10, 32'h0, 4'h0, 0, rd);
    chk("t1_rdata", {32'd0, rd}, {32'd0, 32'hA5A5_1234});

    // 2: three wait states
    txn(1, 32'h04, 32'h1357_9BDF, 4'hF, 3, rd);

    // 3: partial-strobe overwrite
    txn(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1, rd);
    txn(1, 32'h20, 32'h0000_0000, 4'b0101, 0, rd);
    txn(0, 32'h20, 32'h0, 4'h0, 2, rd);
    chk("t3_rdata", {32'd0, rd}, {32'd0, 32'hFF00_FF00});

    // 4: error causes
    txn(0, 32'h7C, 32'h0, 4'h0, 0, rd);
    txn(1, 32'h80, 32'hDEAD_BEEF, 4'hF, 0, rd);
    txn(1, 32'h02, 32'hDEAD_BEEF, 4'hF, 1, rd);
    txn(0, 32'h00, 32'h0, 4'h0, 0, rd);

    // 5: abort during wait states leaves the word unwritten
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h08; pwdata = 32'h5555_AAAA;
    pstrb = 4'hF; pwait = 4'd5;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      penable = 1;
      chk("t5_no_ready", {63'd0, pready}, 64'd0);
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(posedge clk); #1;
    chk("t5_abort_idle", {31'd0, pready, pslverr, prdata}, 64'd0);
    txn(0, 32'h08, 32'h0, 4'h0, 0, rd);

    // 6: reset while a write waits; bitmap cleared afterwards
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'h0BAD_F00D;
    pstrb = 4'hF; pwait = 4'd4;
    @(posedge clk); #1;
    penable = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; psel = 0; penable = 0;
    chk("t6_reset_outputs", {31'd0, pready, pslverr, prdata}, 64'd0);
    model_clear();
    txn(0, 32'h10, 32'h0, 4'h0, 0, rd);
    txn(0, 32'h0C, 32'h0, 4'h0, 1, rd);

    // Random transfers
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom_range(128, 400);
      else if (r == 1) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 7) * 4);
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 4), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
